// File: rtl/piezo_pkg.sv
// piezo_pkg
//   Shared definitions for the piezo tone driver: note codes, the tone
//   frequency table, the FSM state encoding and helpers that turn a clock
//   rate and a tone frequency into a divider half-period (in clocks).
package piezo_pkg;

  // Note codes delivered by the game module; 0 and 9..15 are silent.
  localparam logic [3:0] NOTE_OFF = 4'd0;
  localparam logic [3:0] NOTE_C4  = 4'd1;
  localparam logic [3:0] NOTE_D4  = 4'd2;
  localparam logic [3:0] NOTE_E4  = 4'd3;
  localparam logic [3:0] NOTE_F4  = 4'd4;
  localparam logic [3:0] NOTE_G4  = 4'd5;
  localparam logic [3:0] NOTE_A4  = 4'd6;
  localparam logic [3:0] NOTE_B4  = 4'd7;
  localparam logic [3:0] NOTE_C5  = 4'd8;

  // Tone frequencies in Hz.
  localparam int F_C4    = 262;
  localparam int F_D4    = 294;
  localparam int F_E4    = 330;
  localparam int F_F4    = 349;
  localparam int F_G4    = 392;
  localparam int F_A4    = 440;
  localparam int F_B4    = 494;
  localparam int F_C5    = 523;
  localparam int F_MISS  = 150;
  localparam int F_CHIRP = 1047;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MISS  = 2'd1,
    ST_CHIRP = 2'd2
  } state_e;

  // Clocks per half cycle of a square wave at f Hz (truncated).
  function automatic int half_period(int clk_hz, int f);
    return clk_hz / (2 * f);
  endfunction

  // Frequency of a note code; 0 means silence.
  function automatic int note_freq(logic [3:0] code);
    case (code)
      NOTE_OFF: return 0;
      NOTE_C4:  return F_C4;
      NOTE_D4:  return F_D4;
      NOTE_E4:  return F_E4;
      NOTE_F4:  return F_F4;
      NOTE_G4:  return F_G4;
      NOTE_A4:  return F_A4;
      NOTE_B4:  return F_B4;
      NOTE_C5:  return F_C5;
      default:  return 0;
    endcase
  endfunction

  // Half-period for a note code, 0 for silent codes.
  function automatic int note_half(int clk_hz, logic [3:0] code);
    int f;
    f = note_freq(code);
    return (f == 0) ? 0 : half_period(clk_hz, f);
  endfunction

endpackage

// File: rtl/piezo_tone_driver_divider.sv
// tone_divider
//   Square-wave generator. A wrap counter runs 0..half_i-1; on the wrap the
//   output toggles, giving a period of 2*half_i clocks. restart_i (or run_i
//   low) clears the counter and forces the output low, so the first rising
//   edge after a restart comes half_i clocks later.
// Ports
//   clk        in  clock
//   rst        in  asynchronous active-high reset
//   half_i     in  W  half-period in clocks (held stable while running)
//   restart_i  in  1  clear counter and force wave low this clock
//   run_i      in  1  0 = hold counter at 0 and wave low
//   wave_o     out 1  registered square wave
module tone_divider #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] half_i,
  input  logic         restart_i,
  input  logic         run_i,
  output logic         wave_o
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         wave_q, wave_d;

  always_comb begin
    cnt_d  = cnt_q;
    wave_d = wave_q;
    if (!run_i || restart_i) begin
      cnt_d  = '0;
      wave_d = 1'b0;
    end else if (cnt_q == half_i - W'(1)) begin
      cnt_d  = '0;
      wave_d = ~wave_q;
    end else begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      wave_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wave_q <= wave_d;
    end
  end

  assign wave_o = wave_q;

endmodule

// File: rtl/piezo_tone_driver.sv
// piezo_tone_driver
//   Drives the board piezo from the game's 4-bit note code plus its miss and
//   next-round pulses. Codes 1..8 play C4..C5; a miss pulse plays a 150 Hz
//   buzz and a change pulse a short 1047 Hz chirp, both overriding the note.
// Ports
//   clk           in  system clock
//   reset         in  asynchronous active-high reset
//   enable        in  1 = sound allowed, 0 = mute and abort any effect
//   note_code     in  4  note code, registered every clock
//   miss_pulse    in  starts (or restarts) the miss buzz
//   change_pulse  in  starts (or restarts) the chirp; ignored during the buzz
//   piezo         out square-wave drive
//   busy          out 1 while the buzz or chirp is active
//   tone_on       out 1 while a non-silent half-period is selected
module piezo_tone_driver
  import piezo_pkg::*;
#(
  parameter int CLK_HZ   = 5_000_000,
  parameter int MISS_MS  = 300,
  parameter int CHIRP_MS = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [3:0] note_code,
  input  logic       miss_pulse,
  input  logic       change_pulse,
  output logic       piezo,
  output logic       busy,
  output logic       tone_on
);

  localparam int HW          = $clog2(half_period(CLK_HZ, F_MISS)) + 1;
  localparam int HALF_MISS   = half_period(CLK_HZ, F_MISS);
  localparam int HALF_CHIRP  = half_period(CLK_HZ, F_CHIRP);
  // 64-bit product so large clock rates do not overflow before the divide.
  localparam int MISS_CLKS   = int'((64'(MISS_MS)  * 64'(CLK_HZ)) / 64'd1000);
  localparam int CHIRP_CLKS  = int'((64'(CHIRP_MS) * 64'(CLK_HZ)) / 64'd1000);
  localparam int DUR_MAX     = (MISS_CLKS > CHIRP_CLKS) ? MISS_CLKS : CHIRP_CLKS;
  localparam int DW          = $clog2(DUR_MAX + 1);

  // Half-period lookup per note code, built at elaboration.
  logic [HW-1:0] note_half_tab [16];
  for (genvar gi = 0; gi < 16; gi++) begin : g_note_tab
    assign note_half_tab[gi] = HW'(note_half(CLK_HZ, 4'(gi)));
  end

  logic [3:0]    note_q;
  state_e        state_q, state_d;
  logic [DW-1:0] dur_q, dur_d;
  logic          busy_q, tone_on_q;
  state_e        state_prev_q;
  logic [HW-1:0] half_prev_q;
  logic [HW-1:0] half_sel;
  logic          restart;
  logic          run;

  // Next-state: enable dominates, then miss, then change. A pulse in the
  // same clock as the terminal count wins because it is checked first.
  always_comb begin
    state_d = state_q;
    dur_d   = dur_q;
    if (!enable) begin
      state_d = ST_IDLE;
      dur_d   = '0;
    end else if (miss_pulse) begin
      state_d = ST_MISS;
      dur_d   = '0;
    end else if (change_pulse && (state_q != ST_MISS)) begin
      state_d = ST_CHIRP;
      dur_d   = '0;
    end else begin
      case (state_q)
        ST_MISS: begin
          if (dur_q == DW'(MISS_CLKS - 1)) begin
            state_d = ST_IDLE;
            dur_d   = '0;
          end else begin
            dur_d = dur_q + DW'(1);
          end
        end
        ST_CHIRP: begin
          if (dur_q == DW'(CHIRP_CLKS - 1)) begin
            state_d = ST_IDLE;
            dur_d   = '0;
          end else begin
            dur_d = dur_q + DW'(1);
          end
        end
        default: dur_d = '0;
      endcase
    end
  end

  // Tone selection. enable is used unregistered so muting silences the
  // piezo on the same edge the FSM drops to IDLE.
  always_comb begin
    half_sel = '0;
    if (enable) begin
      case (state_q)
        ST_MISS:  half_sel = HW'(HALF_MISS);
        ST_CHIRP: half_sel = HW'(HALF_CHIRP);
        default:  half_sel = note_half_tab[note_q];
      endcase
    end
  end

  // A change of effect forces a restart even if two tones ever shared a
  // half-period, so every effect start/end begins from a clean low phase.
  assign restart = (half_sel != half_prev_q) || (state_q != state_prev_q);
  assign run     = (half_sel != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      note_q       <= NOTE_OFF;
      state_q      <= ST_IDLE;
      dur_q        <= '0;
      busy_q       <= 1'b0;
      tone_on_q    <= 1'b0;
      state_prev_q <= ST_IDLE;
      half_prev_q  <= '0;
    end else begin
      note_q       <= note_code;
      state_q      <= state_d;
      dur_q        <= dur_d;
      busy_q       <= (state_d != ST_IDLE);
      tone_on_q    <= run;
      state_prev_q <= state_q;
      half_prev_q  <= half_sel;
    end
  end

  tone_divider #(
    .W (HW)
  ) u_div (
    .clk       (clk),
    .rst       (reset),
    .half_i    (half_sel),
    .restart_i (restart),
    .run_i     (run),
    .wave_o    (piezo)
  );

  assign busy    = busy_q;
  assign tone_on = tone_on_q;

endmodule

// File: tb/tb_piezo_tone_driver.sv
module tb_piezo_tone_driver;

  localparam int CLK_HZ     = 100_000;
  localparam int MISS_CLKS  = 30000;
  localparam int CHIRP_CLKS = 10000;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic [3:0] note_code = 4'd0;
  logic       miss_pulse = 1'b0;
  logic       change_pulse = 1'b0;
  logic       piezo, busy, tone_on;

  always #5 clk = ~clk;

  piezo_tone_driver #(
    .CLK_HZ   (CLK_HZ),
    .MISS_MS  (300),
    .CHIRP_MS (100)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .note_code    (note_code),
    .miss_pulse   (miss_pulse),
    .change_pulse (change_pulse),
    .piezo        (piezo),
    .busy         (busy),
    .tone_on      (tone_on)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: effect kind (0 none, 1 miss, 2 chirp), clocks left,
  // registered note, and the edge at which the current tone segment began.
  int     freq_tab [8] = '{262, 294, 330, 349, 392, 440, 494, 523};
  int     m_note, m_eff, m_left, m_prev_half, m_prev_eff;
  longint cyc = 0;
  longint m_seg = 0;
  logic   exp_p = 1'b0, exp_b = 1'b0, exp_t = 1'b0;

  function automatic int ref_half(int code);
    if (code >= 1 && code <= 8) return CLK_HZ / (2 * freq_tab[code-1]);
    return 0;
  endfunction

  task model_reset();
    m_note = 0; m_eff = 0; m_left = 0; m_prev_half = 0; m_prev_eff = 0;
    exp_p = 1'b0; exp_b = 1'b0; exp_t = 1'b0;
  endtask

  // Evaluated at each rising edge with the inputs present at that edge.
  task model_step();
    int half;
    cyc++;
    if (reset) begin
      model_reset();
      return;
    end
    if (!enable)         half = 0;
    else if (m_eff == 1) half = CLK_HZ / (2 * 150);
    else if (m_eff == 2) half = CLK_HZ / (2 * 1047);
    else                 half = ref_half(m_note);
    if (half == 0) begin
      exp_p = 1'b0;
    end else if (half != m_prev_half || m_eff != m_prev_eff) begin
      m_seg = cyc;
      exp_p = 1'b0;
    end else begin
      exp_p = logic'(((cyc - m_seg) / half) % 2);
    end
    exp_t       = (half != 0);
    m_prev_half = half;
    m_prev_eff  = m_eff;
    if (!enable) begin
      m_eff = 0;
    end else if (miss_pulse) begin
      m_eff = 1; m_left = MISS_CLKS;
    end else if (change_pulse && m_eff != 1) begin
      m_eff = 2; m_left = CHIRP_CLKS;
    end else if (m_eff != 0) begin
      m_left--;
      if (m_left == 0) m_eff = 0;
    end
    exp_b  = (m_eff != 0);
    m_note = int'(note_code);
  endtask

  task automatic check(string tag, logic got, logic exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d got=%b exp=%b", tag, cyc, got, exp);
    end
  endtask

  task tick();
    @(posedge clk);
    model_step();
    #1;
    check("piezo", piezo, exp_p);
    check("busy", busy, exp_b);
    check("tone_on", tone_on, exp_t);
    @(negedge clk);
  endtask

  // Occasionally change the note to a random code while ticking.
  task run_random_notes(int n);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 199) == 0) note_code = 4'($urandom_range(0, 15));
      tick();
    end
  endtask

  // Tick until the model's effect ends, with a bounded budget.
  task run_until_idle(int budget);
    int k;
    k = 0;
    while (m_eff != 0 && k < budget) begin
      if ($urandom_range(0, 299) == 0) note_code = 4'($urandom_range(0, 15));
      tick();
      k++;
    end
    checks++;
    if (m_eff != 0) begin
      errors++;
      $display("FAIL effect_end budget=%0d exhausted", budget);
    end
  endtask

  initial begin
    model_reset();
    $display("step reset: note A4 held during reset");
    enable = 1'b1; note_code = 4'd6;
    repeat (3) tick();
    reset = 1'b0;

    $display("step A4 steady tone");
    repeat (400) tick();
    $display("step A4 -> C4 restart");
    note_code = 4'd1;  repeat (400) tick();
    $display("step silent codes 0 and 12");
    note_code = 4'd0;  repeat (50) tick();
    note_code = 4'd12; repeat (50) tick();
    note_code = 4'd6;  repeat (300) tick();
    $display("step random notes in IDLE");
    run_random_notes(1500);
    note_code = 4'd6;  repeat (300) tick();

    $display("step miss+change same clk, change ignored, miss restart at 2000");
    miss_pulse = 1'b1; change_pulse = 1'b1; tick();
    miss_pulse = 1'b0; change_pulse = 1'b0;
    repeat (99) tick();
    change_pulse = 1'b1; tick(); change_pulse = 1'b0;
    run_random_notes(1900);
    miss_pulse = 1'b1; tick(); miss_pulse = 1'b0;
    run_until_idle(MISS_CLKS + 10);
    note_code = 4'd6; repeat (300) tick();

    $display("step chirp, miss 5000 clks in");
    change_pulse = 1'b1; tick(); change_pulse = 1'b0;
    repeat (4999) tick();
    miss_pulse = 1'b1; tick(); miss_pulse = 1'b0;
    run_until_idle(MISS_CLKS + 10);
    note_code = 4'd8; repeat (300) tick();

    $display("step chirp restarted on its terminal clk, then enable=0");
    change_pulse = 1'b1; tick(); change_pulse = 1'b0;
    for (int k = 0; k < CHIRP_CLKS + 5 && m_left != 1; k++) tick();
    change_pulse = 1'b1; tick(); change_pulse = 1'b0;
    repeat (3000) tick();
    enable = 1'b0; tick();
    for (int i = 0; i < 200; i++) begin
      miss_pulse   = 1'($urandom_range(0, 1));
      change_pulse = 1'($urandom_range(0, 1));
      tick();
    end
    miss_pulse = 1'b0; change_pulse = 1'b0;
    enable = 1'b1; repeat (300) tick();

    $display("step async reset mid-miss");
    note_code = 4'd6;
    miss_pulse = 1'b1; tick(); miss_pulse = 1'b0;
    repeat (1000) tick();
    #2 reset = 1'b1;
    #1;
    model_reset();
    check("async_piezo", piezo, 1'b0);
    check("async_busy", busy, 1'b0);
    check("async_tone_on", tone_on, 1'b0);
    @(negedge clk);
    repeat (2) tick();
    reset = 1'b0; note_code = 4'd3;
    repeat (500) tick();
    note_code = 4'd5;
    repeat (500) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
